// File: rtl/nios_system_buttons_pio_pkg.sv
// rtl/nios_system_buttons_pio_pkg.sv - shared constants for the buttons input PIO
package nios_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_buttons_pio_if.sv
// rtl/nios_system_buttons_pio_if.sv - Avalon-MM slave register bus for the input PIO
interface nios_system_buttons_pio_if;
    import nios_pio_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_system_buttons_pio_input_conditioner.sv
// rtl/nios_system_buttons_pio_input_conditioner.sv - pin synchroniser and optional debouncer
module pio_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] stable
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // Bypass reuses the last sync flop so pin-to-capture latency stays SYNC_STAGES+DEBOUNCE_CYCLES.
            assign stable = sync_q[SYNC_STAGES-1];
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] stable_q;
            logic [WIDTH-1:0] sync_last;

            assign sync_last = sync_q[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_q <= '0;
                    for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
                end else begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (sync_last[b] == stable_q[b]) begin
                            cnt[b] <= '0;
                        end else if (cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            stable_q[b] <= sync_last[b];
                            cnt[b]      <= '0;
                        end else begin
                            cnt[b] <= cnt[b] + 1'b1;
                        end
                    end
                end
            end

            assign stable = stable_q;
        end
    endgenerate

endmodule

// File: rtl/nios_system_buttons_pio.sv
// rtl/nios_system_buttons_pio.sv - input PIO: data, irq mask and W1C edge capture registers
module nios_system_buttons_pio
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    nios_system_buttons_pio_if.slave bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    logic [WIDTH-1:0] stable, prev, irq_mask, edge_capture, cap_next;
    logic [WIDTH-1:0] rise, fall, edges, clr;
    logic [SW-1:0]    settle_cnt;
    logic             settled, wr_en;

    pio_input_conditioner #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
        .clk(clk), .reset(reset), .in_port(in_port), .stable(stable)
    );

    assign rise    = stable & ~prev;
    assign fall    = ~stable & prev;
    assign edges   = (EDGE_TYPE == EDGE_RISE) ? rise :
                     (EDGE_TYPE == EDGE_FALL) ? fall : (rise | fall);
    assign settled = (settle_cnt == SW'(SETTLE));
    assign wr_en   = bus.chipselect & ~bus.write_n;

    // Set term is OR'd after the clear so an edge arriving with its own W1C is kept.
    always_comb begin
        clr      = (wr_en && bus.address == PIO_ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
        cap_next = (edge_capture & ~clr) | (settled ? edges : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            settle_cnt   <= '0;
            irq          <= 1'b0;
        end else begin
            prev <= stable;
            if (!settled) settle_cnt <= settle_cnt + 1'b1;
            if (wr_en && bus.address == PIO_ADDR_IRQMASK) irq_mask <= bus.writedata[WIDTH-1:0];
            edge_capture <= cap_next;
            irq          <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            PIO_ADDR_DATA:    bus.readdata[WIDTH-1:0] = stable;
            PIO_ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edge_capture;
            default:          bus.readdata = '0;
        endcase
    end

    generate
        if (WIDTH < BUS_W) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^bus.writedata[BUS_W-1:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_nios_system_buttons_pio.sv
// tb/tb_nios_system_buttons_pio.sv - directed self-checking bench for the buttons input PIO
module tb_nios_system_buttons_pio;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in0, in1, in2;
    logic       irq0, irq1, irq2;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] v;

    nios_system_buttons_pio_if bus0 ();
    nios_system_buttons_pio_if bus1 ();
    nios_system_buttons_pio_if bus2 ();

    nios_system_buttons_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0), .in_port(in0), .irq(irq0));
    nios_system_buttons_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1), .in_port(in1), .irq(irq1));
    nios_system_buttons_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1))
        dut2 (.clk(clk), .reset(reset), .bus(bus2), .in_port(in2), .irq(irq2));

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        case (d)
            0: begin bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = wd; end
            1: begin bus1.chipselect = cs; bus1.write_n = wn; bus1.address = a; bus1.writedata = wd; end
            default: begin bus2.chipselect = cs; bus2.write_n = wn; bus2.address = a; bus2.writedata = wd; end
        endcase
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] wd);
        drive(d, 1'b1, 1'b0, a, wd);
        tick();
        drive(d, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [31:0] r);
        drive(d, 1'b0, 1'b1, a, 32'h0);
        #1;
        case (d)
            0: r = bus0.readdata;
            1: r = bus1.readdata;
            default: r = bus2.readdata;
        endcase
        drive(d, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        in0 = 4'hF; in1 = 4'hF; in2 = 4'hF;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b1, 2'd0, 32'h0);
        tick(2);

        // reset state
        rd(0, 2'd0, v); chk("reset_data", v, 32'h0);
        rd(0, 2'd3, v); chk("reset_cap", v, 32'h0);
        chk("reset_irq", {31'h0, irq0}, 32'h0);

        // pins held high through reset: no spurious rising edge
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("settle_irq", {31'h0, irq0}, 32'h0);
        end
        rd(0, 2'd0, v); chk("settle_data", v, 32'hF);
        rd(0, 2'd3, v); chk("settle_cap", v, 32'h0);
        rd(1, 2'd3, v); chk("settle_cap_fall", v, 32'h0);
        rd(2, 2'd0, v); chk("settle_data_db", v, 32'hF);

        // rising-edge instance ignores a fall, captures the rise
        in0 = 4'hE; tick(4);
        rd(0, 2'd3, v); chk("rise_ignores_fall", v, 32'h0);
        in0 = 4'hF; tick(4);
        rd(0, 2'd3, v); chk("rise_capture", v, 32'h1);

        // falling edge latency, irq and W1C
        wr(1, 2'd2, 32'h1);
        in1 = 4'hE;
        tick(2);
        rd(1, 2'd3, v); chk("fall_k1", v, 32'h0);
        tick();
        rd(1, 2'd3, v); chk("fall_k2", v, 32'h1);
        chk("irq_k2", {31'h0, irq1}, 32'h0);
        tick();
        chk("irq_k3", {31'h0, irq1}, 32'h1);
        wr(1, 2'd3, 32'h1);
        rd(1, 2'd3, v); chk("w1c_cap", v, 32'h0);
        tick();
        chk("w1c_irq", {31'h0, irq1}, 32'h0);

        // debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
        in2 = 4'hB; tick(3); in2 = 4'hF; tick(8);
        rd(2, 2'd0, v); chk("glitch_data", v, 32'hF);
        rd(2, 2'd3, v); chk("glitch_cap", v, 32'h0);
        in2 = 4'hB; tick(4); in2 = 4'hF; tick(2);
        rd(2, 2'd0, v); chk("db_data", v, 32'hB);
        rd(2, 2'd3, v); chk("db_cap_early", v, 32'h0);
        tick();
        rd(2, 2'd3, v); chk("db_cap", v, 32'h4);

        // edge and W1C on the same bit in the same cycle: set wins
        in1 = 4'hC; tick(2);
        wr(1, 2'd3, 32'h2);
        rd(1, 2'd3, v); chk("set_wins", v, 32'h2);
        wr(1, 2'd3, 32'h2);
        rd(1, 2'd3, v); chk("set_wins_clear", v, 32'h0);

        // masked capture, then unmask
        wr(1, 2'd2, 32'h0);
        in1 = 4'h4; tick(4);
        rd(1, 2'd3, v); chk("masked_cap", v, 32'h8);
        chk("masked_irq", {31'h0, irq1}, 32'h0);
        wr(1, 2'd2, 32'h8);
        chk("unmask_irq_0", {31'h0, irq1}, 32'h0);
        tick();
        chk("unmask_irq_1", {31'h0, irq1}, 32'h1);
        rd(1, 2'd1, v); chk("rsvd_read", v, 32'h0);
        wr(1, 2'd1, 32'hFFFF_FFFF);
        rd(1, 2'd1, v); chk("rsvd_after_write", v, 32'h0);
        rd(1, 2'd2, v); chk("mask_read", v, 32'h8);
        rd(1, 2'd0, v); chk("data_read", v, 32'h4);

        // reset mid-operation with pending captures
        wr(1, 2'd3, 32'h8); tick();
        chk("cleared_irq", {31'h0, irq1}, 32'h0);
        in1 = 4'h5; tick(4);
        in1 = 4'h0; tick(4);
        wr(1, 2'd2, 32'h5); tick();
        rd(1, 2'd3, v); chk("pre_reset_cap", v, 32'h5);
        chk("pre_reset_irq", {31'h0, irq1}, 32'h1);
        reset = 1'b1; tick();
        rd(1, 2'd3, v); chk("post_reset_cap", v, 32'h0);
        rd(1, 2'd2, v); chk("post_reset_mask", v, 32'h0);
        chk("post_reset_irq", {31'h0, irq1}, 32'h0);
        reset = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
